// File: rtl/pattern_seq_pkg.sv
// Shared types and helpers for the frame-synchronous pattern select controller.
// Optional auto-cycle support is built when PATTERN_SEQ_AUTO_EN is defined.
package pattern_seq_pkg;

  localparam int FRAME_CNT_W = 16;
  localparam int SEL_W_DEF   = 3;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    MANUAL = 2'd1,
    AUTO   = 2'd2
  } seq_state_e;

  // Out-of-range selects map onto the last legal pattern.
  function automatic int unsigned clamp_sel(input int unsigned sel,
                                            input int unsigned num_patterns);
    return (sel >= num_patterns) ? num_patterns - 1 : sel;
  endfunction

endpackage

// File: rtl/pattern_sequencer_frame_debounce.sv
// Switch synchroniser plus frame-rate debouncer; samples only on frame_tick.
// commit_sel already reflects a commit made in the current tick cycle.
module frame_debounce
  import pattern_seq_pkg::*;
#(
  parameter int SEL_W           = SEL_W_DEF,
  parameter int NUM_PATTERNS    = 8,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic [SEL_W-1:0] SW,
  output logic [SEL_W-1:0] commit_sel
);

  localparam int RUN_W = $clog2(DEBOUNCE_FRAMES + 1);

  logic [SEL_W-1:0] sw_p0, sw_p1;
  logic [SEL_W-1:0] cand, cand_nxt;
  logic [SEL_W-1:0] committed, committed_nxt;
  logic [RUN_W-1:0] run, run_nxt;

  always_comb begin
    cand_nxt      = cand;
    run_nxt       = run;
    committed_nxt = committed;
    if (frame_tick) begin
      if (sw_p1 != cand) begin
        cand_nxt = sw_p1;
        run_nxt  = RUN_W'(1);
      end else if (run != RUN_W'(DEBOUNCE_FRAMES)) begin
        run_nxt = run + RUN_W'(1);
      end
      if (run_nxt == RUN_W'(DEBOUNCE_FRAMES))
        committed_nxt = SEL_W'(clamp_sel(32'(cand_nxt), NUM_PATTERNS));
    end
  end

  assign commit_sel = committed_nxt;

  // p0/p1: two-flop synchroniser for the asynchronous switches
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sw_p0     <= '0;
      sw_p1     <= '0;
      cand      <= '0;
      run       <= '0;
      committed <= '0;
    end else begin
      sw_p0     <= SW;
      sw_p1     <= sw_p0;
      cand      <= cand_nxt;
      run       <= run_nxt;
      committed <= committed_nxt;
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Frame-synchronous pattern select controller between vtc and pg.
// Define PATTERN_SEQ_AUTO_EN to build the AUTO state and step counter.
module pattern_sequencer
  import pattern_seq_pkg::*;
#(
  parameter int SEL_W           = SEL_W_DEF,
  parameter int NUM_PATTERNS    = 8,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int FRAMES_PER_STEP = 60
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   vSync,
  input  logic [SEL_W-1:0]       SW,
  input  logic                   auto_mode,
  output logic [SEL_W-1:0]       pat_sel,
  output logic                   pat_update,
  output logic                   auto_active,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  logic             vsync_p0, vsync_p1;
  logic             frame_tick;
  logic [SEL_W-1:0] commit_sel;
  logic [SEL_W-1:0] sel_nxt;
  seq_state_e       state, state_nxt;

  // p0: registered vSync, p1: its history for the falling-edge strobe
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      vsync_p0 <= 1'b0;
      vsync_p1 <= 1'b0;
    end else begin
      vsync_p0 <= vSync;
      vsync_p1 <= vsync_p0;
    end
  end

  assign frame_tick = vsync_p1 & ~vsync_p0;

  frame_debounce #(
    .SEL_W           (SEL_W),
    .NUM_PATTERNS    (NUM_PATTERNS),
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_debounce (
    .clock      (clock),
    .rst        (rst),
    .frame_tick (frame_tick),
    .SW         (SW),
    .commit_sel (commit_sel)
  );

`ifdef PATTERN_SEQ_AUTO_EN
  localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  logic [STEP_W-1:0] step, step_nxt;

  always_comb begin
    state_nxt = state;
    sel_nxt   = pat_sel;
    step_nxt  = step;
    if (frame_tick) begin
      unique case (state)
        WAIT: state_nxt = MANUAL;
        MANUAL: begin
          if (auto_mode) begin
            state_nxt = AUTO;
            step_nxt  = '0;
          end else begin
            sel_nxt = commit_sel;
          end
        end
        AUTO: begin
          // Leaving AUTO wins over a step wrap due in the same tick.
          if (!auto_mode) begin
            state_nxt = MANUAL;
            sel_nxt   = commit_sel;
          end else if (step == STEP_W'(FRAMES_PER_STEP - 1)) begin
            step_nxt = '0;
            sel_nxt  = (pat_sel == SEL_W'(NUM_PATTERNS - 1)) ? '0 : pat_sel + SEL_W'(1);
          end else begin
            step_nxt = step + STEP_W'(1);
          end
        end
        default: state_nxt = WAIT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) step <= '0;
    else      step <= step_nxt;
  end

  assign auto_active = (state == AUTO);
`else
  logic unused_auto;

  always_comb begin
    state_nxt = state;
    sel_nxt   = pat_sel;
    if (frame_tick) begin
      unique case (state)
        WAIT:    state_nxt = MANUAL;
        MANUAL:  sel_nxt   = commit_sel;
        default: state_nxt = WAIT;
      endcase
    end
  end

  assign unused_auto = auto_mode ^ (FRAMES_PER_STEP == 0);
  assign auto_active = 1'b0;
`endif

  // Output registers: select, change pulse and frame counter
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state       <= WAIT;
      pat_sel     <= '0;
      pat_update  <= 1'b0;
      frame_count <= '0;
    end else begin
      state      <= state_nxt;
      pat_sel    <= sel_nxt;
      pat_update <= (sel_nxt != pat_sel);
      if (frame_tick) frame_count <= frame_count + FRAME_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Randomised frame-level bench for pattern_sequencer with a behavioural reference model.
`timescale 1ns/1ps
module tb_pattern_sequencer;

  localparam int SEL_W = 3;
  localparam int NP    = 6;
  localparam int DF    = 3;
  localparam int FPS   = 4;

`ifdef PATTERN_SEQ_AUTO_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             rst = 1'b0;
  logic             vSync = 1'b1;
  logic [SEL_W-1:0] SW = '0;
  logic             auto_mode = 1'b0;
  logic [SEL_W-1:0] pat_sel;
  logic             pat_update;
  logic             auto_active;
  logic [15:0]      frame_count;

  always #5 clock = ~clock;

  pattern_sequencer #(
    .SEL_W           (SEL_W),
    .NUM_PATTERNS    (NP),
    .DEBOUNCE_FRAMES (DF),
    .FRAMES_PER_STEP (FPS)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .vSync       (vSync),
    .SW          (SW),
    .auto_mode   (auto_mode),
    .pat_sel     (pat_sel),
    .pat_update  (pat_update),
    .auto_active (auto_active),
    .frame_count (frame_count)
  );

  int n_vec = 0;
  int n_bad = 0;
  int n_pulse = 0;
  bit chk_en = 1'b0;

  // Reference model: mode 0 = waiting for first frame, 1 = switch-driven, 2 = auto-cycling
  int m_hist[$];
  int m_commit, m_sel, m_mode, m_step, m_fc;
  bit m_upd, m_auto;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_hist.delete();
    m_commit = 0; m_sel = 0; m_mode = 0; m_step = 0; m_fc = 0;
    m_upd = 1'b0; m_auto = 1'b0;
  endfunction

  function automatic void model_tick(input int s, input bit am);
    int  prev;
    bit  same;
    prev = m_sel;
    m_fc = (m_fc + 1) % 65536;
    m_hist.push_back(s);
    if (m_hist.size() > DF) void'(m_hist.pop_front());
    if (m_hist.size() == DF) begin
      same = 1'b1;
      foreach (m_hist[i]) if (m_hist[i] != s) same = 1'b0;
      if (same) m_commit = (s >= NP) ? NP - 1 : s;
    end
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (AUTO_EN && am) begin
        m_mode = 2;
        m_step = 0;
      end else begin
        m_sel = m_commit;
      end
    end else begin
      if (!am) begin
        m_mode = 1;
        m_sel = m_commit;
      end else if (m_step == FPS - 1) begin
        m_step = 0;
        m_sel = (m_sel + 1) % NP;
      end else begin
        m_step++;
      end
    end
    m_auto = (m_mode == 2);
    m_upd = (m_sel != prev);
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      check("pat_sel", pat_sel, m_sel);
      check("pat_update", pat_update, m_upd);
      check("auto_active", auto_active, m_auto);
      check("frame_count", frame_count, m_fc);
      if (pat_update) n_pulse++;
    end
  end

  // One frame: noisy auto_mode between ticks, then the sampled values held across the tick
  task automatic frame(input int sw, input bit am);
    @(negedge clock);
    SW = SEL_W'(sw);
    vSync = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      auto_mode = 1'($urandom_range(0, 1));
    end
    @(negedge clock);
    auto_mode = am;
    repeat ($urandom_range(2, 5)) @(negedge clock);
    vSync = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 model_tick(sw, am);
    @(posedge clock);
    #1 m_upd = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int sw_r;
    bit am_r;

    model_reset();
    chk_en = 1'b1;
    repeat (3) @(negedge clock);
    rst = 1'b1;
    repeat (4) frame($urandom_range(0, 7), 1'b0);

    // Mid-frame asynchronous reset
    @(negedge clock);
    vSync = 1'b1;
    SW = 3'd5;
    auto_mode = 1'b0;
    repeat (3) @(negedge clock);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("rst_pat_sel", pat_sel, 0);
    check("rst_pat_update", pat_update, 0);
    check("rst_auto_active", auto_active, 0);
    check("rst_frame_count", frame_count, 0);
    repeat (2) @(negedge clock);
    rst = 1'b1;

    p0 = n_pulse;
    frame(5, 1'b0);
    check("t1_first_tick_sel", pat_sel, 0);
    frame(5, 1'b0);
    frame(5, 1'b0);
    check("t1_sel_after_3", pat_sel, 5);
    check("t1_pulses", n_pulse - p0, 1);
    check("t1_frame_count", frame_count, 3);

    // Bouncing switches commit only the stable value
    p0 = n_pulse;
    frame(2, 1'b0);
    frame(3, 1'b0);
    frame(2, 1'b0);
    check("t2_sel_held", pat_sel, 5);
    repeat (3) frame(4, 1'b0);
    check("t2_sel", pat_sel, 4);
    check("t2_pulses", n_pulse - p0, 1);

    repeat (3) frame(7, 1'b0);
    check("t3_clamp", pat_sel, 5);

    // Auto cycling and exit at a due wrap
    repeat (3) frame(4, 1'b0);
    check("t4_start", pat_sel, 4);
    frame(2, 1'b1);
    check("t4_entry_sel", pat_sel, 4);
    check("t4_entry_active", auto_active, AUTO_EN ? 1 : 0);
    repeat (4) frame(2, 1'b1);
    check("t4_step1", pat_sel, AUTO_EN ? 5 : 2);
    repeat (4) frame(2, 1'b1);
    check("t4_step2", pat_sel, AUTO_EN ? 0 : 2);
    repeat (4) frame(2, 1'b1);
    check("t4_step3", pat_sel, AUTO_EN ? 1 : 2);
    repeat (3) frame(2, 1'b1);
    check("t4_hold", pat_sel, AUTO_EN ? 1 : 2);
    frame(2, 1'b0);
    check("t5_exit_sel", pat_sel, 2);
    check("t5_exit_active", auto_active, 0);

    // Frame counter wrap from a preset value
    @(posedge clock);
    #2;
    force dut.frame_count = 16'hFFFF;
    m_fc = 65535;
    @(posedge clock);
    #2;
    release dut.frame_count;
    check("t6_preset", frame_count, 65535);
    frame(2, 1'b0);
    check("t6_wrap", frame_count, 0);

    // Random phase: sticky switches, occasional auto requests
    sw_r = 0;
    am_r = 1'b0;
    for (int i = 0; i < 90; i++) begin
      if ($urandom_range(0, 3) == 0) sw_r = $urandom_range(0, 7);
      if ($urandom_range(0, 7) == 0) am_r = ~am_r;
      frame(sw_r, am_r);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
